// File: rtl/ddr3_pkg.sv
// Shared definitions for the DDR3 command responder.
// Commands are encoded as {CS_N, RAS_N, CAS_N, WE_N}.
package ddr3_pkg;

  localparam logic [3:0] CMD_DES = 4'b1111;
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;
  localparam logic [3:0] CMD_ZQ  = 4'b0110;

  localparam int BL = 8;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_ACT_OPEN   = 3'd1,
    ERR_ACC_CLOSED = 3'd2,
    ERR_BUSY       = 3'd3,
    ERR_REF_OPEN   = 3'd4
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } burst_state_e;

endpackage

// File: rtl/ddr3_resp_mem.sv
// Responder storage: synchronous-read RAM with per-byte write enables.
// Contents are deliberately not reset.
module ddr3_resp_mem #(
  parameter int COL_W = 6
) (
  input  logic               clk,
  input  logic [1:0]         we,
  input  logic               rd,
  input  logic [COL_W+2:0]   addr,
  input  logic [15:0]        wdata,
  output logic [15:0]        rdata
);

  logic [15:0] mem [0:(8 << COL_W)-1];

  always_ff @(posedge clk) begin
    if (we[0]) mem[addr][7:0]  <= wdata[7:0];
    if (we[1]) mem[addr][15:8] <= wdata[15:8];
    if (rd)    rdata           <= mem[addr];
  end

endmodule

// File: rtl/ddr3_cmd_responder.sv
// DRAM-side DDR3 responder: command decode, bank tracking, MR0 capture,
// BL8 read/write burst engine and sticky error reporting.
//
//   state    | meaning
//   ST_IDLE  | no burst in flight; RD/WR may be accepted
//   ST_WAIT  | counting down CL/CWL after an accepted RD/WR
//   ST_BURST | eight data beats, one per clock
import ddr3_pkg::*;

module ddr3_cmd_responder #(
  parameter int CL    = 5,
  parameter int CWL   = 5,
  parameter int COL_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CKE,
  input  logic        CS_N,
  input  logic        RAS_N,
  input  logic        CAS_N,
  input  logic        WE_N,
  input  logic [2:0]  BA,
  input  logic [13:0] ADDR,
  input  logic [15:0] dq_in,
  input  logic [1:0]  dm_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic [13:0] mr0,
  output logic [7:0]  bank_open,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [7:0]  err_count
);

  localparam int AW = COL_W + 3;

  burst_state_e     state, state_next;
  logic [3:0]       cnt, cnt_next;
  logic [2:0]       beat, beat_next;
  logic             is_rd, is_rd_next;
  logic [COL_W-1:0] base, base_next;
  logic [7:0]       bank_next;
  logic [13:0]      mr0_next;
  logic             err_hit;
  err_code_e        err_new, err_code_q;
  logic [3:0]       cmd;
  logic [1:0]       mem_we;
  logic             mem_rd;
  logic [AW-1:0]    mem_addr;
  logic [15:0]      mem_rdata;

  assign cmd = CS_N ? CMD_DES : {1'b0, RAS_N, CAS_N, WE_N};

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    beat_next  = beat;
    is_rd_next = is_rd;
    base_next  = base;
    bank_next  = bank_open;
    mr0_next   = mr0;
    err_hit    = 1'b0;
    err_new    = ERR_NONE;

    case (state)
      ST_WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_next = ST_BURST;
          beat_next  = 3'd0;
        end
      end
      ST_BURST: begin
        beat_next = beat + 3'd1;
        if (beat == 3'(BL - 1)) state_next = ST_IDLE;
      end
      default: ;
    endcase

    if (CKE) begin
      case (cmd)
        CMD_ACT: begin
          if (bank_open[BA]) begin
            err_hit = 1'b1;
            err_new = ERR_ACT_OPEN;
          end else begin
            bank_next[BA] = 1'b1;
          end
        end
        CMD_PRE: begin
          if (ADDR[10]) bank_next = '0;
          else          bank_next[BA] = 1'b0;
        end
        CMD_REF: begin
          if (|bank_open) begin
            err_hit = 1'b1;
            err_new = ERR_REF_OPEN;
          end
        end
        CMD_MRS: begin
          if (BA == 3'd0) mr0_next = ADDR;
        end
        CMD_RD, CMD_WR: begin
          if (!bank_open[BA]) begin
            err_hit = 1'b1;
            err_new = ERR_ACC_CLOSED;
          end else if (state != ST_IDLE) begin
            err_hit = 1'b1;
            err_new = ERR_BUSY;
          end else begin
            state_next = ST_WAIT;
            is_rd_next = (cmd == CMD_RD);
            cnt_next   = (cmd == CMD_RD) ? 4'(CL - 1) : 4'(CWL - 1);
            base_next  = {BA, ADDR[COL_W-1:3]};
            if (ADDR[10]) bank_next[BA] = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      beat       <= '0;
      is_rd      <= 1'b0;
      base       <= '0;
      bank_open  <= '0;
      mr0        <= '0;
      err        <= 1'b0;
      err_code_q <= ERR_NONE;
      err_count  <= '0;
      dq_oe      <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      beat      <= beat_next;
      is_rd     <= is_rd_next;
      base      <= base_next;
      bank_open <= bank_next;
      mr0       <= mr0_next;
      dq_oe     <= (state == ST_BURST) && is_rd;
      if (err_hit) begin
        if (!err) begin
          err        <= 1'b1;
          err_code_q <= err_new;
        end
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

  // Writes are gated by reset so a burst cut short stores nothing further.
  assign mem_we   = (rst && state == ST_BURST && !is_rd) ? ~dm_in : 2'b00;
  assign mem_rd   = (state == ST_BURST) && is_rd;
  assign mem_addr = {base, beat};
  assign dq_out   = dq_oe ? mem_rdata : 16'h0000;
  assign err_code = err_code_q;

  ddr3_resp_mem #(.COL_W(COL_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .rd    (mem_rd),
    .addr  (mem_addr),
    .wdata (dq_in),
    .rdata (mem_rdata)
  );

endmodule
